// File: rtl/err_logger_pkg.sv
// Shared types and helpers for the AXI response error logger.
package err_logger_pkg;

  localparam int unsigned RESP_ERR_BIT = 1;
  localparam int unsigned DefNumPorts  = 5;
  localparam int unsigned DefIdWidth   = 5;

  function automatic int unsigned port_idx_w(input int unsigned num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  // Log entry layout for the default configuration, MSB first.
  typedef struct packed {
    logic [port_idx_w(DefNumPorts)-1:0] port_idx;
    logic                               is_write;
    logic [DefIdWidth-1:0]              id;
    logic [1:0]                         resp;
  } err_entry_t;

endpackage

// File: rtl/err_log_fifo.sv
// Error-log FIFO; registered head, a push into a full FIFO succeeds only with a concurrent pop.
module err_log_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   cnt_q;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == (AddrW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign pop_ok  = pop_i & ~empty_o & ~clear_i;
  assign push_ok = push_i & ~clear_i & (~full_o | pop_ok);
  // Storage is not reset, so mask the head while empty.
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
      else if (pop_ok && !push_ok) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/axi_resp_err_logger.sv
// Passive AXI R/B error monitor: per-port saturating counters, round-robin logging into a FIFO.
module axi_resp_err_logger
  import err_logger_pkg::*;
#(
  parameter int unsigned NumPorts   = 5,
  parameter int unsigned IdWidth    = 5,
  parameter int unsigned CntWidth   = 16,
  parameter int unsigned FifoDepth  = 8,
  localparam int unsigned PortIdxW   = port_idx_w(NumPorts),
  localparam int unsigned EntryWidth = PortIdxW + 1 + IdWidth + 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumPorts-1:0]          r_valid_i,
  input  logic [NumPorts-1:0]          r_ready_i,
  input  logic [NumPorts*2-1:0]        r_resp_i,
  input  logic [NumPorts*IdWidth-1:0]  r_id_i,
  input  logic [NumPorts-1:0]          b_valid_i,
  input  logic [NumPorts-1:0]          b_ready_i,
  input  logic [NumPorts*2-1:0]        b_resp_i,
  input  logic [NumPorts*IdWidth-1:0]  b_id_i,
  input  logic                         clear_i,
  input  logic                         irq_en_i,
  output logic [NumPorts*CntWidth-1:0] r_err_cnt_o,
  output logic [NumPorts*CntWidth-1:0] b_err_cnt_o,
  output logic                         log_valid_o,
  input  logic                         log_ready_i,
  output logic [EntryWidth-1:0]        log_entry_o,
  output logic [CntWidth-1:0]          dropped_cnt_o,
  output logic                         overflow_o,
  output logic                         irq_o
);

  localparam int unsigned NumSrc = 2 * NumPorts;
  localparam int unsigned SrcW   = $clog2(NumSrc);
  localparam int unsigned SumW   = CntWidth + SrcW + 1;
  localparam logic [CntWidth-1:0] CntMax = '1;

  typedef struct packed {
    logic [PortIdxW-1:0] port_idx;
    logic                is_write;
    logic [IdWidth-1:0]  id;
    logic [1:0]          resp;
  } entry_t;

  logic [NumSrc-1:0]   ev;
  logic                gnt_valid;
  logic [SrcW-1:0]     gnt_idx;
  logic [SrcW-1:0]     rr_q, rr_d;
  logic [SrcW:0]       n_ev, n_drop;
  logic                fifo_full, fifo_empty, pop, pushed;
  entry_t              entry;
  logic [EntryWidth-1:0] head;
  logic [CntWidth-1:0] r_cnt_q [NumPorts];
  logic [CntWidth-1:0] b_cnt_q [NumPorts];
  logic [CntWidth-1:0] dropped_q, dropped_d;
  logic [SumW-1:0]     drop_sum;
  logic                overflow_q;

  // Source index 2*p is the R channel of port p, 2*p+1 the B channel.
  always_comb begin
    ev = '0;
    for (int p = 0; p < NumPorts; p++) begin
      ev[2*p]   = r_valid_i[p] & r_ready_i[p] & r_resp_i[2*p+RESP_ERR_BIT];
      ev[2*p+1] = b_valid_i[p] & b_ready_i[p] & b_resp_i[2*p+RESP_ERR_BIT];
    end
  end

  always_comb begin
    int idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    n_ev      = '0;
    for (int k = 0; k < NumSrc; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= int'(NumSrc)) idx = idx - int'(NumSrc);
      if (ev[idx] && !gnt_valid) begin
        gnt_valid = 1'b1;
        gnt_idx   = SrcW'(idx);
      end
      n_ev = n_ev + (SrcW+1)'(ev[k]);
    end
  end

  always_comb begin
    entry = '0;
    for (int s = 0; s < NumSrc; s++) begin
      if (gnt_idx == SrcW'(s)) begin
        entry.port_idx = PortIdxW'(s / 2);
        entry.is_write = (s % 2 == 1);
        if (s % 2 == 0) begin
          entry.id   = r_id_i[(s/2)*IdWidth +: IdWidth];
          entry.resp = r_resp_i[s +: 2];
        end else begin
          entry.id   = b_id_i[(s/2)*IdWidth +: IdWidth];
          entry.resp = b_resp_i[(s-1) +: 2];
        end
      end
    end
  end

  assign pop       = ~fifo_empty & log_ready_i & ~clear_i;
  assign pushed    = gnt_valid & ~clear_i & (~fifo_full | pop);
  assign n_drop    = n_ev - (SrcW+1)'(pushed);
  assign drop_sum  = SumW'(dropped_q) + SumW'(n_drop);
  assign dropped_d = (drop_sum > SumW'(CntMax)) ? CntMax : drop_sum[CntWidth-1:0];

  always_comb begin
    rr_d = rr_q;
    if (gnt_valid) rr_d = (gnt_idx == SrcW'(NumSrc - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      dropped_q  <= '0;
      overflow_q <= 1'b0;
      for (int p = 0; p < NumPorts; p++) begin
        r_cnt_q[p] <= '0;
        b_cnt_q[p] <= '0;
      end
    end else if (clear_i) begin
      rr_q       <= '0;
      dropped_q  <= '0;
      overflow_q <= 1'b0;
      for (int p = 0; p < NumPorts; p++) begin
        r_cnt_q[p] <= '0;
        b_cnt_q[p] <= '0;
      end
    end else begin
      rr_q      <= rr_d;
      dropped_q <= dropped_d;
      if (n_drop != '0) overflow_q <= 1'b1;
      for (int p = 0; p < NumPorts; p++) begin
        if (ev[2*p] && r_cnt_q[p] != CntMax)   r_cnt_q[p] <= r_cnt_q[p] + 1'b1;
        if (ev[2*p+1] && b_cnt_q[p] != CntMax) b_cnt_q[p] <= b_cnt_q[p] + 1'b1;
      end
    end
  end

  err_log_fifo #(
    .Width (EntryWidth),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (pushed),
    .pop_i   (pop),
    .data_i  (entry),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    r_err_cnt_o = '0;
    b_err_cnt_o = '0;
    for (int p = 0; p < NumPorts; p++) begin
      r_err_cnt_o[p*CntWidth +: CntWidth] = r_cnt_q[p];
      b_err_cnt_o[p*CntWidth +: CntWidth] = b_cnt_q[p];
    end
  end

  assign log_valid_o   = ~fifo_empty;
  assign log_entry_o   = head;
  assign irq_o         = irq_en_i & ~fifo_empty;
  assign dropped_cnt_o = dropped_q;
  assign overflow_o    = overflow_q;

endmodule

// File: doc/axi_resp_err_logger.md
Name: axi_resp_err_logger

Overview:
- Synthesizable successor to the simulation-only R/B error check in the CVA6 host wrapper.
- Snoops the R and B channels of NumPorts AXI ports: per-core SPU/CCU ports plus the post-remap master.
- Counts DECERR/SLVERR responses per port and channel with saturating counters.
- Logs error details into a FIFO that software drains, and raises a level interrupt while entries are pending.
- Passive observer only; it never drives valid/ready.

Parameters:
- NumPorts, 5: number of monitored AXI ports (at least 1).
- IdWidth, 5: AXI ID width; all ports are zero-extended to this width.
- CntWidth, 16: width of each saturating error counter.
- FifoDepth, 8: error-log entries; a power of two, at least 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- r_valid_i  in  NumPorts  R valid per port
- r_ready_i  in  NumPorts  R ready per port
- r_resp_i  in  NumPorts*2  R resp per port
- r_id_i  in  NumPorts*IdWidth  R id per port
- b_valid_i  in  NumPorts  B valid per port
- b_ready_i  in  NumPorts  B ready per port
- b_resp_i  in  NumPorts*2  B resp per port
- b_id_i  in  NumPorts*IdWidth  B id per port
- clear_i  in  1  synchronous clear of counters, FIFO and sticky flags
- irq_en_i  in  1  interrupt enable
- r_err_cnt_o  out  NumPorts*CntWidth  read-error counts
- b_err_cnt_o  out  NumPorts*CntWidth  write-error counts
- log_valid_o  out  1  FIFO head valid
- log_ready_i  in  1  pop head
- log_entry_o  out  EntryWidth  head entry {port_idx, is_write, id, resp}
- dropped_cnt_o  out  CntWidth  errors not logged because the FIFO was full or lost arbitration
- overflow_o  out  1  sticky; set when any error is dropped
- irq_o  out  1  level interrupt

Behaviour:
- Reset: all counters 0, FIFO empty, rr pointer 0, overflow_o 0. Consequently log_valid_o 0, irq_o 0, log_entry_o 0.
- Error event: valid & ready & resp[1]==1, i.e. SLVERR (2'b10) or DECERR (2'b11). OKAY and EXOKAY are ignored. Valid without ready is not an event.
- Counters: an event on port p at cycle t makes the corresponding count visible at t+1 (+1). Counters saturate at all-ones and never wrap.
- Sources: 2*NumPorts sources, index = 2*p + is_write, so R has even indices and B has odd.
- Arbitration:
  - At most one source is logged per cycle.
  - Round-robin starting at rr_ptr; after a grant, rr_ptr becomes granted index + 1, modulo 2*NumPorts.
  - With no events, rr_ptr holds.
- Losing sources are still counted in their own counters. Each one also increments dropped_cnt_o (saturating) and sets overflow_o.
- FIFO:
  - The granted event is pushed if the FIFO is not full. If full, it is dropped and counted as above, and the FIFO contents are unchanged.
  - Pop when log_valid_o & log_ready_i.
  - Push and pop in the same cycle are both allowed when full: the pop frees the slot, the push succeeds, and the count is unchanged.
  - Push into an empty FIFO is visible at the head on the next cycle; there is no fall-through.
- dropped_cnt_o increments by the number of dropped events that cycle, saturating.
- irq_o = irq_en_i & log_valid_o. It is combinational from registered state, so it rises at t+1 after the first logged error.
- clear_i takes priority over everything:
  - Zeroes all counters, overflow_o, dropped_cnt_o and the FIFO, and resets rr_ptr to 0.
  - Events and pops in the same cycle are discarded.
- Asynchronous reset mid-operation returns everything to the reset values immediately. Partial state is never kept.
- Entry layout, MSB to LSB: port_idx [PortIdxW], is_write [1], id [IdWidth], resp [2].
  - PortIdxW = max(1, $clog2(NumPorts)).

Decomposition:
- Shared package err_logger_pkg holds:
  - the PortIdxW function;
  - the entry struct type err_entry_t;
  - the RESP_ERR_BIT constant.
- Natural sub-module: err_log_fifo.
  - Parametric depth with full/empty flags.
  - Allows push and pop in the same cycle when full.
- Arbiter and counters live in the top.

Test Plan:
- Single error: port 2 R handshake with resp 2'b11, id 5'h03 at cycle 10.
  - Cycle 11: r_err_cnt[2]=1, log_valid_o=1, entry={2,0,3,2'b11}, irq_o=1 with irq_en_i=1.
- Simultaneous errors: port 0 B and port 3 R error in the same cycle with rr_ptr=0.
  - Port 0 B (index 1) is logged and port 3 R is dropped; dropped_cnt_o=1, overflow_o=1.
  - rr_ptr=2, and both counters are 1.
- FIFO full: 9 consecutive port-1 R errors with FifoDepth=8 and no pops.
  - 8 entries logged, 9th dropped; dropped_cnt_o=1, r_err_cnt[1]=9.
- Full plus simultaneous pop: with the FIFO full, assert log_ready_i and inject one error.
  - The push succeeds, occupancy stays 8, and dropped_cnt_o is unchanged.
- Saturation: CntWidth=4, 20 port-0 R errors → r_err_cnt[0]=15.
- Clear priority: clear_i together with an error and a pop.
  - Next cycle all counters are 0, log_valid_o=0, irq_o=0, overflow_o=0.
- Asynchronous reset mid-burst: rst_ni low while errors are active.
  - All outputs read 0 immediately, with no wait for a clock edge.
